// File: rtl/peripheral_pkg.sv
// Address map and shared constants for peripheral_system_n.
// PERIPH_PHASE_TIMESTAMP_EN (in the top) widens phase FIFO entries with a cycle timestamp.
package peripheral_pkg;

  localparam logic [26:0] COMM_REGISTER0    = 27'h000_0000;
  localparam logic [26:0] COMM_CONTROL      = 27'h000_0001;
  localparam logic [26:0] PHASE_REG         = 27'h000_0002;
  localparam logic [26:0] CPC_METRIC_SWITCH = 27'h000_0003;
  localparam logic [26:0] STATS_BASE        = 27'h000_0004;
  localparam logic [26:0] STATS_SNAPSHOT    = 27'h000_0005;
  localparam logic [26:0] PHASE_FIFO_STATUS = 27'h000_0006;
  localparam logic [26:0] PHASE_FIFO_DATA   = 27'h000_0007;
  localparam logic [26:0] PHASE_FIFO_TS     = 27'h000_0008;
  localparam logic [26:0] COMM_CACHE_BASE   = 27'h000_0010;
  // Cache channels are decoded inside a fixed 16-word window; unpopulated slots read 0.
  localparam logic [26:0] CACHE_WINDOW      = 27'd16;

  localparam logic [31:0] RESET_READ_VAL    = 32'hDEADBEAF;
  localparam int          CS_CTRL_PULSE_BIT = 23;

endpackage

// File: rtl/periph_phase_fifo.sv
// Synchronous FIFO for phase events with sticky overflow; a pop frees a slot for a same-cycle push.
// Entry width is set by the top (31 bits, or 63 with PERIPH_PHASE_TIMESTAMP_EN).
module periph_phase_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 31,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop_ok, push_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (clr_ovf_i)           ovf_d = 1'b0;
    if (push_i && !push_ok)  ovf_d = 1'b1;
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/peripheral_system_n.sv
// Core/cs peripheral register block: mailbox, comm control, metric select, cache read-back,
// counter stats with snapshot bank and a queued phase register. Option: PERIPH_PHASE_TIMESTAMP_EN.
module peripheral_system_n
  import peripheral_pkg::*;
#(
  parameter int N_CACHE     = 3,
  parameter int N_COUNTERS  = 6,
  parameter int METRIC_W    = 2,
  parameter int PHASE_DEPTH = 8
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    req_core_i,
  input  logic                    rw_core_i,
  input  logic [26:0]             add_core_i,
  input  logic [31:0]             data_core_i,
  output logic [31:0]             data_core_o,
  input  logic                    req_cs_i,
  input  logic                    rw_cs_i,
  input  logic [26:0]             add_cs_i,
  input  logic [31:0]             data_cs_i,
  output logic [31:0]             data_cs_o,
  input  logic [32*N_COUNTERS-1:0] cycle_counts_i,
  input  logic [32*N_CACHE-1:0]   comm_cache_i,
  output logic [METRIC_W-1:0]     metric_sel_o,
  output logic [31:0]             phase_o,
  output logic [31:0]             comm_o,
  output logic                    phase_pending_o
);

  localparam int CNT_W = $clog2(PHASE_DEPTH) + 1;
`ifdef PERIPH_PHASE_TIMESTAMP_EN
  localparam int FIFO_W = 63;
`else
  localparam int FIFO_W = 31;
`endif

  logic [N_COUNTERS-1:0][31:0] live;
  logic [N_CACHE-1:0][31:0]    cache;
  assign live  = cycle_counts_i;
  assign cache = comm_cache_i;

  logic [31:0]                 comm_reg0_q, comm_reg0_d;
  logic [7:0]                  core_ctrl_q, core_ctrl_d;
  logic [23:0]                 cs_ctrl_q, cs_ctrl_d;
  logic [METRIC_W-1:0]         metric_q, metric_d;
  logic [31:0]                 phase_q, phase_d;
  logic [N_COUNTERS-1:0][31:0] snap_q, snap_d;
  logic [31:0]                 stats_q, stats_d;
  logic [31:0]                 data_core_q, data_core_d;
  logic [31:0]                 data_cs_q, data_cs_d;
  logic [31:0]                 ts_rd;

  logic core_wr, core_rd, cs_wr, cs_rd;
  logic phase_push, fifo_pop, ovf_clr;
  logic [FIFO_W-1:0] push_data, head;
  logic              empty, full, overflow;
  logic [CNT_W-1:0]  count;
  logic [26:0]       cache_off;
  logic              unused_ok;

  assign core_wr    = req_core_i && rw_core_i;
  assign core_rd    = req_core_i && !rw_core_i;
  assign cs_wr      = req_cs_i && rw_cs_i;
  assign cs_rd      = req_cs_i && !rw_cs_i;
  assign phase_push = core_wr && (add_core_i == PHASE_REG);
  assign fifo_pop   = cs_rd && (add_cs_i == PHASE_FIFO_DATA);
  assign ovf_clr    = cs_wr && (add_cs_i == PHASE_FIFO_STATUS);
  assign cache_off  = add_cs_i - COMM_CACHE_BASE;
  assign unused_ok  = ^{data_core_i[31], data_cs_i[31:24], full};

`ifdef PERIPH_PHASE_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d, ts_reg_q, ts_reg_d;
  assign push_data = {ts_q, data_core_i[30:0]};
  assign ts_rd     = ts_reg_q;

  always_comb begin
    ts_d     = ts_q + 32'd1;
    ts_reg_d = ts_reg_q;
    if (fifo_pop && !empty) ts_reg_d = head[62:31];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ts_q     <= '0;
      ts_reg_q <= '0;
    end else begin
      ts_q     <= ts_d;
      ts_reg_q <= ts_reg_d;
    end
  end
`else
  assign push_data = data_core_i[30:0];
  assign ts_rd     = '0;
`endif

  periph_phase_fifo #(.DEPTH(PHASE_DEPTH), .WIDTH(FIFO_W)) u_phase_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (phase_push),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .clr_ovf_i   (ovf_clr),
    .head_o      (head),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  always_comb begin
    comm_reg0_d = comm_reg0_q;
    core_ctrl_d = core_ctrl_q;
    cs_ctrl_d   = cs_ctrl_q;
    cs_ctrl_d[CS_CTRL_PULSE_BIT] = 1'b0;
    metric_d    = metric_q;
    phase_d     = {1'b0, phase_q[30:0]};
    snap_d      = snap_q;
    stats_d     = stats_q;
    data_core_d = data_core_q;
    data_cs_d   = data_cs_q;

    if (core_wr && add_core_i == COMM_REGISTER0) comm_reg0_d = data_core_i;
    if (core_wr && add_core_i == COMM_CONTROL)   core_ctrl_d = data_core_i[7:0];
    if (phase_push)                              phase_d     = {1'b1, data_core_i[30:0]};
    if (core_rd && add_core_i == COMM_REGISTER0) data_core_d = comm_reg0_q;

    if (cs_wr) begin
      case (add_cs_i)
        COMM_CONTROL:      cs_ctrl_d = data_cs_i[23:0];
        CPC_METRIC_SWITCH: metric_d  = data_cs_i[METRIC_W-1:0];
        STATS_SNAPSHOT:    snap_d    = live;
        STATS_BASE: begin
          stats_d = '0;
          for (int k = 0; k < N_COUNTERS; k++)
            if (data_cs_i[7:0] == 8'(k)) stats_d = data_cs_i[8] ? snap_q[k] : live[k];
        end
        default: ;
      endcase
    end

    if (cs_rd) begin
      data_cs_d = '0;
      case (add_cs_i)
        COMM_REGISTER0:    data_cs_d = comm_reg0_q;
        STATS_BASE:        data_cs_d = stats_q;
        PHASE_FIFO_STATUS: data_cs_d = {overflow, 15'b0, 16'(count)};
        PHASE_FIFO_DATA:   data_cs_d = empty ? 32'h0 : {1'b1, head[30:0]};
        PHASE_FIFO_TS:     data_cs_d = ts_rd;
        default: begin
          if (add_cs_i >= COMM_CACHE_BASE && add_cs_i < COMM_CACHE_BASE + CACHE_WINDOW)
            for (int i = 0; i < N_CACHE; i++)
              if (cache_off == 27'(i)) data_cs_d = cache[i];
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      comm_reg0_q <= '0;
      core_ctrl_q <= '0;
      cs_ctrl_q   <= '0;
      metric_q    <= '0;
      phase_q     <= '0;
      snap_q      <= '0;
      stats_q     <= '0;
      data_core_q <= RESET_READ_VAL;
      data_cs_q   <= RESET_READ_VAL;
    end else begin
      comm_reg0_q <= comm_reg0_d;
      core_ctrl_q <= core_ctrl_d;
      cs_ctrl_q   <= cs_ctrl_d;
      metric_q    <= metric_d;
      phase_q     <= phase_d;
      snap_q      <= snap_d;
      stats_q     <= stats_d;
      data_core_q <= data_core_d;
      data_cs_q   <= data_cs_d;
    end
  end

  assign data_core_o     = data_core_q;
  assign data_cs_o       = data_cs_q;
  assign metric_sel_o    = metric_q;
  assign phase_o         = phase_q;
  assign comm_o          = {core_ctrl_q, cs_ctrl_q};
  assign phase_pending_o = !empty;

endmodule

// File: tb/tb_peripheral_system_n.sv
// Scoreboard bench for peripheral_system_n: read expectations are queued at issue, checked one cycle later.
module tb_peripheral_system_n;
  import peripheral_pkg::*;

  localparam int N_CACHE = 3, N_COUNTERS = 6, METRIC_W = 2, PHASE_DEPTH = 8;

  logic clock_i = 1'b0;
  logic reset_i;
  logic req_core_i, rw_core_i, req_cs_i, rw_cs_i;
  logic [26:0] add_core_i, add_cs_i;
  logic [31:0] data_core_i, data_cs_i, data_core_o, data_cs_o;
  logic [32*N_COUNTERS-1:0] cycle_counts_i;
  logic [32*N_CACHE-1:0] comm_cache_i;
  logic [METRIC_W-1:0] metric_sel_o;
  logic [31:0] phase_o, comm_o;
  logic phase_pending_o;

  always #5 clock_i = ~clock_i;

  peripheral_system_n #(.N_CACHE(N_CACHE), .N_COUNTERS(N_COUNTERS), .METRIC_W(METRIC_W),
                        .PHASE_DEPTH(PHASE_DEPTH)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req_core_i(req_core_i), .rw_core_i(rw_core_i), .add_core_i(add_core_i),
    .data_core_i(data_core_i), .data_core_o(data_core_o),
    .req_cs_i(req_cs_i), .rw_cs_i(rw_cs_i), .add_cs_i(add_cs_i),
    .data_cs_i(data_cs_i), .data_cs_o(data_cs_o),
    .cycle_counts_i(cycle_counts_i), .comm_cache_i(comm_cache_i),
    .metric_sel_o(metric_sel_o), .phase_o(phase_o), .comm_o(comm_o),
    .phase_pending_o(phase_pending_o)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_cs_q[$], exp_core_q[$];
  string       tag_cs_q[$], tag_core_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge and drop both request strobes.
  task automatic tick();
    @(negedge clock_i);
    req_core_i = 1'b0;
    req_cs_i   = 1'b0;
  endtask

  task automatic core_wr(input logic [26:0] a, input logic [31:0] d);
    req_core_i = 1'b1; rw_core_i = 1'b1; add_core_i = a; data_core_i = d;
  endtask

  task automatic core_rd(input logic [26:0] a, input logic [31:0] e, input string t);
    req_core_i = 1'b1; rw_core_i = 1'b0; add_core_i = a;
    exp_core_q.push_back(e); tag_core_q.push_back(t);
  endtask

  task automatic cs_wr(input logic [26:0] a, input logic [31:0] d);
    req_cs_i = 1'b1; rw_cs_i = 1'b1; add_cs_i = a; data_cs_i = d;
  endtask

  task automatic cs_rd(input logic [26:0] a, input logic [31:0] e, input string t);
    req_cs_i = 1'b1; rw_cs_i = 1'b0; add_cs_i = a;
    exp_cs_q.push_back(e); tag_cs_q.push_back(t);
  endtask

  always @(posedge clock_i) begin : sb_mon
    logic cs_hit, core_hit;
    cs_hit   = req_cs_i && !rw_cs_i && !reset_i;
    core_hit = req_core_i && !rw_core_i && !reset_i;
    #2;
    if (cs_hit && exp_cs_q.size() != 0)
      check(tag_cs_q.pop_front(), data_cs_o, exp_cs_q.pop_front());
    if (core_hit && exp_core_q.size() != 0)
      check(tag_core_q.pop_front(), data_core_o, exp_core_q.pop_front());
  end

`ifdef PERIPH_PHASE_TIMESTAMP_EN
  logic [31:0] ts_m;
  always @(posedge clock_i) ts_m <= reset_i ? 32'h0 : ts_m + 32'd1;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t_cap;
    reset_i = 1'b1;
    req_core_i = 1'b0; rw_core_i = 1'b0; add_core_i = '0; data_core_i = '0;
    req_cs_i = 1'b0;   rw_cs_i = 1'b0;   add_cs_i = '0;   data_cs_i = '0;
    cycle_counts_i = '0;
    comm_cache_i = {32'h5A5A_0002, 32'hA5A5_0001, 32'h1111_0000};
    t_cap = '0;

    repeat (2) @(negedge clock_i);
    check("rst_data_cs", data_cs_o, 32'hDEADBEAF);
    check("rst_data_core", data_core_o, 32'hDEADBEAF);
    check("rst_phase", phase_o, 32'h0);
    check("rst_comm", comm_o, 32'h0);
    check("rst_metric", 32'(metric_sel_o), 32'h0);
    check("rst_pending", 32'(phase_pending_o), 32'h0);
    reset_i = 1'b0;

    // Cache read-back and mailbox
    cs_rd(COMM_CACHE_BASE + 27'd1, 32'hA5A5_0001, "cache1"); tick();
    cs_rd(COMM_CACHE_BASE, 32'h1111_0000, "cache0"); tick();
    cs_rd(COMM_CACHE_BASE + 27'd2, 32'h5A5A_0002, "cache2"); tick();
    cs_rd(COMM_CACHE_BASE + 27'd3, 32'h0, "cache3_absent"); tick();
    core_wr(COMM_REGISTER0, 32'h1234_5678); tick();
    core_rd(COMM_REGISTER0, 32'h1234_5678, "core_cr0");
    cs_rd(COMM_REGISTER0, 32'h1234_5678, "cs_cr0"); tick();
    core_rd(27'h100, 32'h1234_5678, "core_unmapped_hold");
    cs_rd(27'h100, 32'h0, "cs_unmapped_zero"); tick();

    // Back-to-back phase writes
    core_wr(PHASE_REG, 32'h0000_0042); tick();
    check("phase_first", phase_o, 32'h8000_0042);
    core_wr(PHASE_REG, 32'h0000_0043); tick();
    check("phase_second", phase_o, 32'h8000_0043);
    check("pending_set", 32'(phase_pending_o), 32'h1);
    tick();
    check("phase_pulse_clear", phase_o, 32'h0000_0043);
    cs_rd(PHASE_FIFO_STATUS, 32'h0000_0002, "status_2"); tick();
    cs_rd(PHASE_FIFO_DATA, 32'h8000_0042, "pop_42"); tick();
    cs_rd(PHASE_FIFO_DATA, 32'h8000_0043, "pop_43"); tick();
    cs_rd(PHASE_FIFO_DATA, 32'h0, "pop_empty"); tick();
    check("pending_clear", 32'(phase_pending_o), 32'h0);

    // Overflow, flag clear, full push+pop, empty push+pop
    for (int i = 0; i < 9; i++) begin
      core_wr(PHASE_REG, 32'h100 + 32'(i)); tick();
    end
    cs_rd(PHASE_FIFO_STATUS, 32'h8000_0008, "status_ovf"); tick();
    cs_wr(PHASE_FIFO_STATUS, 32'h0); tick();
    cs_rd(PHASE_FIFO_STATUS, 32'h0000_0008, "status_ovf_clr"); tick();
    core_wr(PHASE_REG, 32'h200);
    cs_rd(PHASE_FIFO_DATA, 32'h8000_0100, "full_pushpop"); tick();
    cs_rd(PHASE_FIFO_STATUS, 32'h0000_0008, "status_full_pushpop"); tick();
    for (int i = 1; i < 8; i++) begin
      cs_rd(PHASE_FIFO_DATA, 32'h8000_0100 + 32'(i), "drain"); tick();
    end
    cs_rd(PHASE_FIFO_DATA, 32'h8000_0200, "drain_late_push"); tick();
    cs_rd(PHASE_FIFO_DATA, 32'h0, "drain_empty"); tick();
    core_wr(PHASE_REG, 32'h300);
    cs_rd(PHASE_FIFO_DATA, 32'h0, "empty_pushpop"); tick();
    cs_rd(PHASE_FIFO_DATA, 32'h8000_0300, "empty_pushpop_stored"); tick();

    // Stats snapshot vs live
    cycle_counts_i[64 +: 32]  = 32'd100;
    cycle_counts_i[160 +: 32] = 32'd55;
    cs_wr(STATS_SNAPSHOT, 32'h0); tick();
    cycle_counts_i[64 +: 32]  = 32'd200;
    cycle_counts_i[160 +: 32] = 32'd77;
    cs_wr(STATS_BASE, 32'h102); tick();
    cs_rd(STATS_BASE, 32'd100, "stats_snap2"); tick();
    cs_wr(STATS_BASE, 32'h002); tick();
    cs_rd(STATS_BASE, 32'd200, "stats_live2"); tick();
    cs_wr(STATS_BASE, 32'h007); tick();
    cs_rd(STATS_BASE, 32'd0, "stats_idx7"); tick();
    cs_wr(STATS_BASE, 32'h105); tick();
    cs_rd(STATS_BASE, 32'd55, "stats_snap5"); tick();

    // Comm control pulse and metric select
    cs_wr(COMM_CONTROL, 32'h0080_0001);
    core_wr(COMM_CONTROL, 32'h0000_00AB); tick();
    check("comm_pulse", comm_o, 32'hAB80_0001);
    tick();
    check("comm_after_pulse", comm_o, 32'hAB00_0001);
    cs_wr(CPC_METRIC_SWITCH, 32'hFFFF_FFFE); tick();
    check("metric", 32'(metric_sel_o), 32'h2);

    // Timestamp read-back
`ifdef PERIPH_PHASE_TIMESTAMP_EN
    t_cap = ts_m;
`endif
    core_wr(PHASE_REG, 32'h77); tick();
    cs_rd(PHASE_FIFO_DATA, 32'h8000_0077, "ts_pop"); tick();
    cs_rd(PHASE_FIFO_TS, t_cap, "ts_read"); tick();

    // Reset mid-operation discards queued phase events
    core_wr(PHASE_REG, 32'h55); tick();
    check("pending_before_rst", 32'(phase_pending_o), 32'h1);
    reset_i = 1'b1; tick();
    reset_i = 1'b0;
    check("pending_after_rst", 32'(phase_pending_o), 32'h0);
    check("core_after_rst", data_core_o, 32'hDEADBEAF);
    check("phase_after_rst", phase_o, 32'h0);
    cs_rd(PHASE_FIFO_DATA, 32'h0, "pop_after_rst"); tick();

    repeat (3) tick();
    check("sb_drain", 32'(exp_cs_q.size() + exp_core_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/peripheral_system_n.md
Name: peripheral_system_n

Overview:
- Parametrised successor of the single-core peripheral register block.
- Sits between the core bus and the control-system (cs) bus.
- Provides:
  - a mailbox register;
  - comm control pulses;
  - a metric select output;
  - an N-channel cache comm read-back;
  - N-counter cycle-stat access with an atomic snapshot bank;
  - a phase register whose every update is queued in a phase-event FIFO, so the cs drains phase changes without loss.

Parameters:
- N_CACHE, 3, number of 32-bit cache comm input channels.
- N_COUNTERS, 6, number of 32-bit cycle counters on cycle_counts_i.
- METRIC_W, 2, width of metric_sel_o.
- PHASE_DEPTH, 8, phase FIFO depth (power of two, >=2).

Ports:
- clock_i  in  1  system clock; all logic on its rising edge.
- reset_i  in  1  synchronous reset, active-high.
- req_core_i  in  1  core request strobe.
- rw_core_i  in  1  1 = write, 0 = read.
- add_core_i  in  27  core address.
- data_core_i  in  32  core write data.
- data_core_o  out  32  core read data (registered).
- req_cs_i  in  1  cs request strobe.
- rw_cs_i  in  1  1 = write, 0 = read.
- add_cs_i  in  27  cs address.
- data_cs_i  in  32  cs write data.
- data_cs_o  out  32  cs read data (registered).
- cycle_counts_i  in  32*N_COUNTERS  live counters; counter k occupies bits [32k+31:32k].
- comm_cache_i  in  32*N_CACHE  cache comm words; channel i occupies bits [32i+31:32i].
- metric_sel_o  out  METRIC_W  metric select.
- phase_o  out  32  phase register; bit 31 is a one-cycle update pulse.
- comm_o  out  32  {core_ctrl[7:0], cs_ctrl[23:0]}.
- phase_pending_o  out  1  phase FIFO non-empty.

Behaviour:
- Reset (reset_i=1 at posedge):
  - data_core_o = data_cs_o = 32'hDEADBEAF.
  - All registers, metric_sel_o, phase_o, comm_o, FIFO pointers, overflow flag, snapshot bank and timestamp are cleared to 0.
  - Reset mid-operation discards the FIFO contents.
- Reads: latency 1 cycle; data is valid on the cycle after the req edge.
  - Core unmapped read: data_core_o holds its previous value.
  - cs unmapped read: data_cs_o = 0.
- Core writes:
  - COMM_REGISTER0 <- data.
  - COMM_CONTROL: core_ctrl <- data[7:0].
  - PHASE_REG:
    - phase_o <- {1, data[30:0]}.
    - Push data[30:0] to the FIFO.
    - Bit 31 self-clears the next cycle unless another PHASE_REG write arrives.
- Core reads: COMM_REGISTER0 only.
- cs writes:
  - COMM_CONTROL: cs_ctrl <- data[23:0]. cs_ctrl[23] self-clears after one cycle (buffer-clear pulse).
  - CPC_METRIC_SWITCH: metric_sel <- data[METRIC_W-1:0].
  - STATS_SNAPSHOT: copy all N_COUNTERS live counters into the snapshot bank in the same cycle.
  - STATS_BASE: stats_reg <- counter[data[7:0]].
    - Source is the snapshot bank if data[8]=1, else live.
    - Index >= N_COUNTERS -> 0.
  - PHASE_FIFO_STATUS: any write clears the overflow flag.
- cs reads:
  - COMM_REGISTER0.
  - STATS_BASE -> stats_reg.
  - COMM_CACHE_BASE+i -> channel i; i >= N_CACHE -> 0.
  - PHASE_FIFO_STATUS -> {overflow, 15'b0, count[15:0]}.
  - PHASE_FIFO_DATA:
    - Non-empty: returns {1, head[30:0]} and pops.
    - Empty: returns 0, no pop.
  - PHASE_FIFO_TS: see Optional Feature.
- FIFO boundaries:
  - Push when full: entry dropped, overflow set (sticky), count stays PHASE_DEPTH.
  - Push and pop in the same cycle, non-empty: both occur, count unchanged.
  - Push and pop in the same cycle, empty: the pop returns 0; the push is stored.
  - Push and pop in the same cycle, full: the pop frees a slot, so the push is accepted and no overflow is set.
  - Pointers wrap modulo PHASE_DEPTH.
  - count is log2(PHASE_DEPTH)+1 bits, zero-extended.
- Simultaneous core and cs accesses are independent; no shared writable register.

Optional Feature:
- Macro: PERIPH_PHASE_TIMESTAMP_EN.
- Enabled:
  - A free-running 32-bit cycle timestamp (wraps at 2^32) is captured with each FIFO push.
  - A PHASE_FIFO_DATA pop latches that entry's timestamp into ts_reg.
  - PHASE_FIFO_TS reads ts_reg.
- Disabled: no timestamp storage; PHASE_FIFO_TS reads 0.

Decomposition:
- Package peripheral_pkg holds:
  - all address constants: COMM_REGISTER0, COMM_CONTROL, PHASE_REG, CPC_METRIC_SWITCH, STATS_BASE, STATS_SNAPSHOT, PHASE_FIFO_STATUS, PHASE_FIFO_DATA, PHASE_FIFO_TS, COMM_CACHE_BASE;
  - the reset read value 32'hDEADBEAF;
  - the cs_ctrl pulse bit index 23.
- Sub-module periph_phase_fifo: parametrised depth/width synchronous FIFO with full/empty/count outputs and overflow flag; width is 31, or 63 with timestamp.

Test Plan:
- Reset, then cs read COMM_CACHE_BASE+1 with comm_cache_i channel 1 = 32'hA5A5_0001 -> data_cs_o = 32'hDEADBEAF during reset, then 32'hA5A5_0001 one cycle after the read.
- Core writes PHASE_REG 32'h0000_0042, then a second write 32'h0000_0043 on the following cycle; no further PHASE_REG writes follow:
  - phase_o = 32'h8000_0042, then 32'h8000_0043, then 32'h0000_0043 (bit 31 pulse held for the back-to-back write, clearing one cycle after the last);
  - status count = 2;
  - two PHASE_FIFO_DATA reads return 32'h8000_0042 then 32'h8000_0043;
  - a third read returns 0.
- Nine PHASE_REG writes with PHASE_DEPTH=8:
  - status = 32'h8000_0008;
  - status write clears the flag -> 32'h0000_0008;
  - the ninth value is absent.
- Snapshot with counter 2 = 100, then live counter 2 = 200:
  - STATS_BASE write 32'h102 then read -> 100;
  - write 32'h002 then read -> 200;
  - index 7 -> 0.
- cs writes COMM_CONTROL 32'h0080_0001 -> comm_o[23] high for exactly one cycle, comm_o[22:0] = 1 persists.
- With PERIPH_PHASE_TIMESTAMP_EN: a push at timestamp T, then a pop, then a PHASE_FIFO_TS read -> T.
